cgra_dmem_responder: RTL and testbench

CGRA_DMEM_RESPONDER -- requirements
Module: cgra_dmem_responder

---
 rtl/cgra_dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_cgra_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cgra_dmem_responder.sv
// ---------------------------------------------------------------------------
// cgra_dmem_responder
//
// Shared single-port data memory for a CGRA. N_REQ tile requesters compete
// through a round-robin arbiter; one request is accepted per cycle. Stores
// write at the end of the grant cycle and return nothing. Loads are fully
// pipelined: memory read into stage 1 at the end of the grant cycle, stage 2
// drives the response, so resp_valid rises two cycles after the grant.
//
// Optional feature macro: CGRA_DMEM_ERR_EN
//   defined   : addresses >= DEPTH do not write memory; loads return 0 with
//               resp_err = 1.
//   undefined : addresses wrap modulo DEPTH; resp_err is always 0.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   [N_REQ]     per-tile request valid
//   req_ready   out  [N_REQ]     per-tile grant (one-hot or zero)
//   req_we      in   [N_REQ]     1 = store, 0 = load
//   req_addr    in   [10*N_REQ]  word address, tile i at [10i+9:10i]
//   req_wdata   in   [32*N_REQ]  store data, tile i at [32i+31:32i]
//   req_tag     in   [3*N_REQ]   load destination register index
//   resp_valid  out  [N_REQ]     one-hot load-data strobe
//   resp_data   out  [32]        load data (shared)
//   resp_tag    out  [3]         echoed tag
//   resp_err    out  [1]         out-of-range load
// ---------------------------------------------------------------------------
module cgra_dmem_responder #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [10*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  input  logic [3*N_REQ-1:0]    req_tag,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [31:0]           resp_data,
  output logic [2:0]            resp_tag,
  output logic                  resp_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem [DEPTH];

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant;
  logic             gnt_any;
  logic [PW-1:0]    gnt_id;
  logic [PW:0]      cand;

  logic             sel_we;
  logic [9:0]       sel_addr;
  logic [31:0]      sel_wdata;
  logic [2:0]       sel_tag;
  logic             in_range;
  logic [AW-1:0]    mem_idx;

  logic             s1_valid_q;
  logic [31:0]      s1_data_q;
  logic [2:0]       s1_tag_q;
  logic [PW-1:0]    s1_id_q;
  logic             s1_err_q;

  logic [N_REQ-1:0] resp_valid_q;
  logic [31:0]      resp_data_q;
  logic [2:0]       resp_tag_q;
  logic             resp_err_q;

  // Round-robin search: candidates rr_ptr, rr_ptr+1, ... wrapped at N_REQ.
  // Nothing is granted while rst is high.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!gnt_any && !rst && req_valid[cand[PW-1:0]]) begin
        grant[cand[PW-1:0]] = 1'b1;
        gnt_any             = 1'b1;
        gnt_id              = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_id == PW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  assign req_ready = grant;

  // Grant is one-hot, so an OR-style mux over the granted tile is enough.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_tag   = '0;
    for (int g = 0; g < N_REQ; g++) begin
      if (grant[g]) begin
        sel_we    = req_we[g];
        sel_addr  = req_addr[10*g +: 10];
        sel_wdata = req_wdata[32*g +: 32];
        sel_tag   = req_tag[3*g +: 3];
      end
    end
  end

`ifdef CGRA_DMEM_ERR_EN
  assign in_range = ({1'b0, sel_addr} < 11'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  // Without the error check this truncation is the modulo-DEPTH wrap.
  assign mem_idx = sel_addr[AW-1:0];

  // Memory has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (gnt_any && sel_we && in_range) begin
      mem[mem_idx] <= sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Stage 1: registered memory read. A store in the previous cycle has
  // already landed in mem, so a following load sees the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_id_q    <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= gnt_any && !sel_we;
      if (gnt_any && !sel_we) begin
        s1_data_q <= in_range ? mem[mem_idx] : '0;
        s1_tag_q  <= sel_tag;
        s1_id_q   <= gnt_id;
        s1_err_q  <= !in_range;
      end
    end
  end

  // Stage 2: response registers; payload holds while no response is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= s1_valid_q ? (N_REQ'(1) << s1_id_q) : '0;
      if (s1_valid_q) begin
        resp_data_q <= s1_data_q;
        resp_tag_q  <= s1_tag_q;
        resp_err_q  <= s1_err_q;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_cgra_dmem_responder.sv
module tb_cgra_dmem_responder;

  localparam int N     = 4;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_we, resp_valid;
  logic [10*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [3*N-1:0]  req_tag;
  logic [31:0]   resp_data;
  logic [2:0]    resp_tag;
  logic          resp_err;

  int checks = 0;
  int errors = 0;

  cgra_dmem_responder #(.N_REQ(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_tag   = '0;
  endtask

  task automatic set_req(input int t, input logic we, input logic [9:0] a,
                         input logic [31:0] d, input logic [2:0] tg);
    req_valid[t]          = 1'b1;
    req_we[t]             = we;
    req_addr[10*t +: 10]  = a;
    req_wdata[32*t +: 32] = d;
    req_tag[3*t +: 3]     = tg;
  endtask

  initial begin
    // Reset state and no acceptance during reset
    rst = 1'b1;
    clear_req();
    tick();
    tick();
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data",  resp_data,        32'h0);
    check("rst_resp_tag",   32'(resp_tag),    32'h0);
    check("rst_resp_err",   32'(resp_err),    32'h0);
    req_valid = 4'hF;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("rst_no_accept", 32'(resp_valid), 32'h0);
    clear_req();
    rst = 1'b0;

    // Store then load same address next cycle
    set_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 3'd0);
    #1;
    check("st_ready", 32'(req_ready), 32'h1);
    tick();
    clear_req();
    set_req(0, 1'b0, 10'd5, 32'h0, 3'd3);
    #1;
    check("ld_ready_wrap", 32'(req_ready), 32'h1);
    tick();
    clear_req();
    check("lat1_no_resp", 32'(resp_valid), 32'h0);
    tick();
    check("raw_valid", 32'(resp_valid), 32'h1);
    check("raw_data",  resp_data,        32'hDEADBEEF);
    check("raw_tag",   32'(resp_tag),    32'h3);
    check("raw_err",   32'(resp_err),    32'h0);
    tick();
    check("one_cycle_valid", 32'(resp_valid), 32'h0);
    check("hold_data",       resp_data,        32'hDEADBEEF);
    check("hold_tag",        32'(resp_tag),    32'h3);

    // Round-robin order with all tiles requesting, rr_ptr restarted at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < N; t++) set_req(t, 1'b0, 10'd5, 32'h0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_grant_%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
      tick();
    end
    clear_req();
    tick();
    tick();
    tick();

    // Back-to-back loads on tile 2
    for (int a = 1; a <= 3; a++) begin
      clear_req();
      set_req(2, 1'b1, 10'(a), 32'(11 * a), 3'd0);
      #1;
      check($sformatf("st_b2b_ready_%0d", a), 32'(req_ready), 32'h4);
      tick();
    end
    clear_req();
    set_req(2, 1'b0, 10'd1, 32'h0, 3'd1);
    tick();
    set_req(2, 1'b0, 10'd2, 32'h0, 3'd2);
    tick();
    check("b2b0_valid", 32'(resp_valid), 32'h4);
    check("b2b0_data",  resp_data,        32'd11);
    check("b2b0_tag",   32'(resp_tag),    32'h1);
    set_req(2, 1'b0, 10'd3, 32'h0, 3'd4);
    tick();
    clear_req();
    check("b2b1_valid", 32'(resp_valid), 32'h4);
    check("b2b1_data",  resp_data,        32'd22);
    check("b2b1_tag",   32'(resp_tag),    32'h2);
    tick();
    check("b2b2_valid", 32'(resp_valid), 32'h4);
    check("b2b2_data",  resp_data,        32'd33);
    check("b2b2_tag",   32'(resp_tag),    32'h4);
    tick();
    check("b2b_end", 32'(resp_valid), 32'h0);

    // Reset one cycle after a load grant discards the load
    set_req(1, 1'b0, 10'd2, 32'h0, 3'd6);
    #1;
    check("pre_rst_ready", 32'(req_ready), 32'h2);
    tick();
    clear_req();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_data", resp_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_no_resp_%0d", i), 32'(resp_valid), 32'h0);
      tick();
    end
    req_valid = 4'hF;
    #1;
    check("post_rst_ptr0", 32'(req_ready), 32'h1);
    clear_req();
    set_req(3, 1'b0, 10'd5, 32'h0, 3'd7);
    tick();
    clear_req();
    tick();
    check("mem_kept_valid", 32'(resp_valid), 32'h8);
    check("mem_kept_data",  resp_data,        32'hDEADBEEF);
    check("mem_kept_tag",   32'(resp_tag),    32'h7);

    // Out-of-range address with DEPTH = 512
    set_req(0, 1'b1, 10'd88, 32'h55555555, 3'd0);
    tick();
    clear_req();
    set_req(0, 1'b1, 10'd600, 32'h00001234, 3'd0);
    tick();
    clear_req();
    set_req(0, 1'b0, 10'd600, 32'h0, 3'd5);
    tick();
    clear_req();
    tick();
    check("oor_valid", 32'(resp_valid), 32'h1);
    check("oor_tag",   32'(resp_tag),    32'h5);
`ifdef CGRA_DMEM_ERR_EN
    check("oor_data", resp_data,      32'h0);
    check("oor_err",  32'(resp_err),  32'h1);
`else
    check("oor_data", resp_data,      32'h00001234);
    check("oor_err",  32'(resp_err),  32'h0);
`endif
    set_req(0, 1'b0, 10'd88, 32'h0, 3'd6);
    tick();
    clear_req();
    tick();
    check("alias_valid", 32'(resp_valid), 32'h1);
    check("alias_err",   32'(resp_err),   32'h0);
`ifdef CGRA_DMEM_ERR_EN
    check("alias_data", resp_data, 32'h55555555);
`else
    check("alias_data", resp_data, 32'h00001234);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
